param_regfile: RTL and testbench

//  Parametrised successor to the KGP-RISC register file: 2 async read ports, 1 sync write port.

---
 rtl/param_regfile_if.sv | 40 ++++
 rtl/param_regfile.sv | 171 +++++++++++++++++
 tb/tb_param_regfile.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/param_regfile_if.sv
// param_regfile_if
//   Bundles the register-file bus: two read ports, the byte-enabled write
//   port, the bulk-clear handshake and the debug result tap. Clock and reset
//   stay outside the bundle as plain module ports.
//
//   master : the decode / write-back side that issues reads, writes and clears
//   slave  : the register file itself
//
//   readreg1/2  read indices             readdata1/2  combinational read data
//   writereg    write index              writedata    write data
//   regwrite    write enable             wr_be        per-byte write enables
//   clr_req     bulk-clear request       clr_busy     clear engine running
//   clr_done    one-cycle completion     result_reg   debug view of one register
interface param_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0]   readreg1;
    logic [ADDR_WIDTH-1:0]   readreg2;
    logic [DATA_WIDTH-1:0]   readdata1;
    logic [DATA_WIDTH-1:0]   readdata2;
    logic [ADDR_WIDTH-1:0]   writereg;
    logic [DATA_WIDTH-1:0]   writedata;
    logic                    regwrite;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic                    clr_req;
    logic                    clr_busy;
    logic                    clr_done;
    logic [DATA_WIDTH-1:0]   result_reg;

    modport master (
        output readreg1, readreg2, writereg, writedata, regwrite, wr_be, clr_req,
        input  readdata1, readdata2, clr_busy, clr_done, result_reg
    );

    modport slave (
        input  readreg1, readreg2, writereg, writedata, regwrite, wr_be, clr_req,
        output readdata1, readdata2, clr_busy, clr_done, result_reg
    );
endinterface

// File: rtl/param_regfile.sv
// param_regfile
//   Parametrised register file: two combinational read ports, one clocked
//   write port with byte enables, optional write->read bypass, optional
//   hardwired-zero R0, and a sequenced bulk-clear engine that zeroes one
//   register per cycle while reporting busy/done.
//
//   clk    rising-edge clock
//   reset  synchronous, active-low; clears every register and the clear engine
//   bus    param_regfile_if.slave (read ports, write port, clear handshake,
//          result_reg debug tap)
module param_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b0,
    parameter int RESULT_IDX = 0
) (
    input  logic            clk,
    input  logic            reset,
    param_regfile_if.slave  bus
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] RESULT_ADDR = ADDR_WIDTH'(RESULT_IDX);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];

    logic [DATA_WIDTH-1:0]   byte_mask;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    write_discard;
    logic                    write_live;
    logic                    last_clear;

    // Selects the stored word, the merged in-flight write, or zero for one
    // read port. Zero wins during reset and for a hardwired R0; the bypass
    // only applies while a write is actually going to commit.
    function automatic logic [DATA_WIDTH-1:0] port_value(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  in_reset,
        input logic                  live,
        input logic [ADDR_WIDTH-1:0] wr_idx,
        input logic [DATA_WIDTH-1:0] wr_merged
    );
        logic [DATA_WIDTH-1:0] value;
        value = stored;
        if (BYPASS && live && (idx == wr_idx)) begin
            value = wr_merged;
        end
        if (ZERO_REG && (idx == '0)) begin
            value = '0;
        end
        if (in_reset) begin
            value = '0;
        end
        return value;
    endfunction

    // Write qualification and the byte-merged value that a write would
    // commit; the same merged word feeds the bypass path so readers see
    // exactly what lands in the array.
    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            byte_mask[8*i +: 8] = {8{bus.wr_be[i]}};
        end
        write_discard = ZERO_REG && (bus.writereg == '0);
        write_live    = (state == IDLE) && bus.regwrite && (bus.wr_be != '0) && !write_discard;
        merged        = (regs[bus.writereg] & ~byte_mask) | (bus.writedata & byte_mask);
        last_clear    = (state == CLEAR) && (cnt == LAST_IDX);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic: a request from IDLE starts a sweep, and the
    // sweep ends on the edge that clears the highest index. Requests that
    // arrive mid-sweep are simply not looked at.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: busy follows the state directly, done is the registered
    // completion pulse.
    always_comb begin
        bus.clr_busy = (state == CLEAR);
        bus.clr_done = done_q;
    end

    // Sweep counter: parked at 0 while idle so every sweep starts at R0,
    // and allowed to wrap back to 0 after the last index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Completion pulse, registered so it appears in the first IDLE cycle
    // after the sweep. Reset suppresses it, which is what keeps an aborted
    // sweep from looking finished.
    always_ff @(posedge clk) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_clear;
        end
    end

    // Register array: reset wipes everything, the sweep zeroes one entry per
    // cycle and locks out normal writes, otherwise a qualified write commits
    // its byte-merged value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (write_live) begin
            regs[bus.writereg] <= merged;
        end
    end

    // Read ports and the debug tap all go through the same selection so
    // reset forcing, R0 zeroing and bypass behave identically on each.
    always_comb begin
        bus.readdata1  = port_value(bus.readreg1, regs[bus.readreg1], !reset,
                                    write_live, bus.writereg, merged);
        bus.readdata2  = port_value(bus.readreg2, regs[bus.readreg2], !reset,
                                    write_live, bus.writereg, merged);
        bus.result_reg = port_value(RESULT_ADDR, regs[RESULT_ADDR], !reset,
                                    write_live, bus.writereg, merged);
    end

endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile
//   Self-checking bench for param_regfile with default parameters
//   (32 x 32-bit, bypass on, R0 writable, result_reg tapping R0).
//   A word-level model of the register file tracks every clock edge; a
//   negedge process compares all outputs against it each cycle, and the
//   directed phases add literal expectations.
module tb_param_regfile;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    param_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    param_regfile #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BYPASS     (1'b1),
        .ZERO_REG   (1'b0),
        .RESULT_IDX (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mdl [DEPTH];
    bit mdl_busy = 1'b0;
    int mdl_pos  = 0;
    bit mdl_done = 1'b0;
    bit check_en = 1'b0;

    int busy_cnt;
    int done_cnt;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [AW-1:0] wreg,
                                 input logic [DW-1:0] wd, input logic [3:0] be,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                 input logic clr);
        bus.regwrite  = wr;
        bus.writereg  = wreg;
        bus.writedata = wd;
        bus.wr_be     = be;
        bus.readreg1  = r1;
        bus.readreg2  = r2;
        bus.clr_req   = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // What a read of idx must return right now: stored word, overlaid with
    // the enabled bytes of a write that is about to commit.
    function automatic logic [DW-1:0] expected_read(input logic [AW-1:0] idx);
        logic [DW-1:0] v;
        if (reset !== 1'b1) return '0;
        v = mdl[idx];
        if (!mdl_busy && bus.regwrite && idx == bus.writereg) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wr_be[b]) v[8*b +: 8] = bus.writedata[8*b +: 8];
            end
        end
        return v;
    endfunction

    // Model update on each rising edge.
    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
            mdl_busy = 1'b0;
            mdl_pos  = 0;
            mdl_done = 1'b0;
        end else if (mdl_busy) begin
            mdl[mdl_pos] = '0;
            if (mdl_pos == DEPTH - 1) begin
                mdl_busy = 1'b0;
                mdl_done = 1'b1;
            end else begin
                mdl_pos  = mdl_pos + 1;
                mdl_done = 1'b0;
            end
        end else begin
            mdl_done = 1'b0;
            if (bus.regwrite) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.wr_be[b]) mdl[bus.writereg][8*b +: 8] = bus.writedata[8*b +: 8];
                end
            end
            if (bus.clr_req) begin
                mdl_busy = 1'b1;
                mdl_pos  = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("readdata1",  bus.readdata1,     expected_read(bus.readreg1));
            checkOutput("readdata2",  bus.readdata2,     expected_read(bus.readreg2));
            checkOutput("result_reg", bus.result_reg,    expected_read('0));
            checkOutput("clr_busy",   DW'(bus.clr_busy), DW'(mdl_busy));
            checkOutput("clr_done",   DW'(bus.clr_done), DW'(mdl_done));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, 4'h0, '0, '0, 1'b0);
        step();
        check_en = 1'b1;
        step();
        reset = 1'b1;

        // Reset state
        applyStimulus(1'b0, '0, '0, 4'h0, 5'd0, 5'd10, 1'b0);
        #2;
        checkOutput("reset_r0",   bus.readdata1, 32'd0);
        checkOutput("reset_r10",  bus.readdata2, 32'd0);
        checkOutput("reset_busy", DW'(bus.clr_busy), 32'd0);
        checkOutput("reset_done", DW'(bus.clr_done), 32'd0);

        // Plain writes
        applyStimulus(1'b1, 5'd0,  32'd25,  4'hF, 5'd0, 5'd10, 1'b0); step();
        applyStimulus(1'b1, 5'd2,  32'd55,  4'hF, 5'd0, 5'd10, 1'b0); step();
        applyStimulus(1'b1, 5'd10, 32'd100, 4'hF, 5'd0, 5'd10, 1'b0); step();
        applyStimulus(1'b0, '0, '0, 4'h0, 5'd0, 5'd10, 1'b0);
        #2;
        checkOutput("write_r0",  bus.readdata1, 32'd25);
        checkOutput("write_r10", bus.readdata2, 32'd100);
        checkOutput("result_r0", bus.result_reg, 32'd25);

        // Same-cycle bypass
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd2, 1'b0);
        #2;
        checkOutput("bypass_before_edge", bus.readdata1, 32'hDEADBEEF);
        checkOutput("r2_kept",            bus.readdata2, 32'd55);
        step();
        applyStimulus(1'b0, '0, '0, 4'h0, 5'd5, 5'd2, 1'b0);
        #2;
        checkOutput("bypass_after_edge", bus.readdata1, 32'hDEADBEEF);

        // Byte enables
        applyStimulus(1'b1, 5'd3, 32'h11223344, 4'hF,    5'd3, 5'd3, 1'b0); step();
        applyStimulus(1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 5'd3, 5'd3, 1'b0);
        #2;
        checkOutput("be_bypass_merge", bus.readdata1, 32'h11BB33DD);
        step();
        applyStimulus(1'b0, '0, '0, 4'h0, 5'd3, 5'd3, 1'b0);
        #2;
        checkOutput("be_merge", bus.readdata1, 32'h11BB33DD);
        applyStimulus(1'b1, 5'd3, 32'hFFFFFFFF, 4'h0, 5'd3, 5'd3, 1'b0); step();
        applyStimulus(1'b0, '0, '0, 4'h0, 5'd3, 5'd3, 1'b0);
        #2;
        checkOutput("be_zero_no_write", bus.readdata1, 32'h11BB33DD);

        // Randomized traffic, including occasional clears and writes during them
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                          AW'($urandom), AW'($urandom), ($urandom_range(0, 29) == 0));
            step();
        end
        applyStimulus(1'b0, '0, '0, 4'h0, '0, '0, 1'b0);
        for (int n = 0; n < 64 && bus.clr_busy; n++) step();
        checkOutput("drain_busy_timeout", DW'(bus.clr_busy), 32'd0);
        step();

        // Fill every register, then sweep
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, AW'(i), 32'h01010101 * (i + 1), 4'hF, AW'(i), 5'd31, 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, '0, 4'h0, 5'd7, 5'd31, 1'b0);
        #2;
        checkOutput("fill_r7",  bus.readdata1, 32'h08080808);
        checkOutput("fill_r31", bus.readdata2, 32'h20202020);

        applyStimulus(1'b0, '0, '0, 4'h0, 5'd7, 5'd31, 1'b1);
        step();
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(i == 20, 5'd7, 32'd9, 4'hF, 5'd7, 5'd31, 1'b0);
            #2;
            if (bus.clr_busy) busy_cnt++;
            if (bus.clr_done) done_cnt++;
            step();
        end
        applyStimulus(1'b0, '0, '0, 4'h0, 5'd7, 5'd31, 1'b0);
        #2;
        checkOutput("clear_busy_cycles", DW'(busy_cnt), 32'd32);
        checkOutput("clear_done_pulses", DW'(done_cnt), 32'd1);
        checkOutput("dropped_write_r7",  bus.readdata1, 32'd0);
        checkOutput("cleared_r31",       bus.readdata2, 32'd0);

        // Refill a few, then reset in the 10th busy cycle
        applyStimulus(1'b1, 5'd20, 32'h12345678, 4'hF, '0, '0, 1'b0); step();
        applyStimulus(1'b0, '0, '0, 4'h0, '0, '0, 1'b1);
        step();
        for (int k = 1; k < 10; k++) begin
            applyStimulus(1'b0, '0, '0, 4'h0, '0, '0, 1'b0);
            step();
        end
        #2;
        checkOutput("busy_before_reset", DW'(bus.clr_busy), 32'd1);
        reset = 1'b0;
        step();
        checkOutput("busy_after_reset", DW'(bus.clr_busy), 32'd0);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, '0, '0, 4'h0, AW'(i), AW'(31 - i), 1'b0);
            #2;
            if (bus.clr_done) done_cnt++;
            if (i < DEPTH) checkOutput("post_reset_zero", bus.readdata1, 32'd0);
            step();
        end
        checkOutput("no_done_after_reset", DW'(done_cnt), 32'd0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
